// File: rtl/dmem_bus.sv
// Data-memory subsystem: parametrised word RAM with byte/half/word access,
// fault detection and a four-register MMIO window (DISP, CYCLE, STATUS).
module dmem_bus #(
  parameter logic [31:0] DATA_BASE   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 2048,
  parameter logic [31:0] MMIO_BASE   = 32'h1002_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        range_err,
  output logic [31:0] disp_data
);
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) << 2;

  logic [31:0] ram_off, mmio_off;
  logic        ram_hit, mmio_hit, acc_ok, ram_we, mmio_we;
  logic [AW-1:0] widx;
  logic [3:0]  be;
  logic [31:0] wrep, ram_word, lane_sh, ram_load, mmio_rd;
  logic [31:0] disp_q, disp_d, cycle_q, cycle_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] mem [DEPTH_WORDS];

  assign ram_off  = addr - DATA_BASE;
  assign mmio_off = addr - MMIO_BASE;
  // RAM wins if a parameter choice ever makes the two windows overlap
  assign ram_hit  = ram_off < RAM_BYTES;
  assign mmio_hit = !ram_hit && (mmio_off < 32'd16);
  assign widx     = ram_off[AW+1:2];

  always_comb begin
    misalign  = 1'b0;
    range_err = 1'b0;
    if (ena) begin
      misalign = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
      if (!misalign)
        range_err = (size == 2'b11) || !(ram_hit || mmio_hit) ||
                    (mmio_hit && size != 2'b10);
    end
  end

  assign acc_ok  = ena && !misalign && !range_err;
  assign ram_we  = acc_ok && wr && ram_hit;
  assign mmio_we = acc_ok && wr && mmio_hit;

  always_comb begin
    be   = 4'b0000;
    wrep = wdata;
    unique case (size)
      2'b00:   begin be = 4'b0001 << addr[1:0]; wrep = {4{wdata[7:0]}};  end
      2'b01:   begin be = 4'b0011 << addr[1:0]; wrep = {2{wdata[15:0]}}; end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // RAM is never cleared; a store coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (ram_we && !reset)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wrep[8*i +: 8];
  end

  assign ram_word = mem[widx];
  assign lane_sh  = ram_word >> {addr[1:0], 3'b000};

  always_comb begin
    unique case (size)
      2'b00:   ram_load = {{24{sign_ext & lane_sh[7]}},  lane_sh[7:0]};
      2'b01:   ram_load = {{16{sign_ext & lane_sh[15]}}, lane_sh[15:0]};
      default: ram_load = lane_sh;
    endcase
  end

  always_comb begin
    unique case (mmio_off[3:2])
      2'd0:    mmio_rd = disp_q;
      2'd1:    mmio_rd = cycle_q;
      2'd2:    mmio_rd = {30'd0, status_q};
      default: mmio_rd = 32'd0;
    endcase
  end

  assign rdata = acc_ok ? (ram_hit ? ram_load : mmio_rd) : 32'd0;

  always_comb begin
    disp_d   = disp_q;
    status_d = status_q;
    cycle_d  = cycle_q + 32'd1;
    if (mmio_we && mmio_off[3:2] == 2'd0) disp_d = wdata;
    if (mmio_we && mmio_off[3:2] == 2'd2) status_d = status_q & ~wdata[1:0];
    // a W1C access is never faulted, so set and clear never collide
    if (misalign)  status_d[0] = 1'b1;
    if (range_err) status_d[1] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q   <= 32'd0;
      cycle_q  <= 32'd0;
      status_q <= 2'b00;
    end else begin
      disp_q   <= disp_d;
      cycle_q  <= cycle_d;
      status_q <= status_d;
    end
  end

  assign disp_data = disp_q;
endmodule
